// File: rtl/mc_ctrl_irq.sv
// mc_ctrl_irq: multicycle MIPS control FSM with vectored interrupts, precise
// exceptions and a ready/timeout handshake on DM and device accesses.
module mc_ctrl_irq #(
    parameter int          IRQ_W       = 6,
    parameter int          MEM_TIMEOUT = 15,
    parameter logic [23:0] DEV_BASE    = 24'h00007f
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_instr,
    input  logic [29:0]      i_pr_addr,
    input  logic             i_zero,
    input  logic             i_ovf,
    input  logic [IRQ_W-1:0] i_irq,
    input  logic [IRQ_W-1:0] i_im,
    input  logic             i_ie,
    input  logic             i_exl,
    input  logic             i_mem_ready,
    output logic             o_pc_wr,
    output logic             o_ir_wr,
    output logic             o_gpr_wr,
    output logic [2:0]       o_npc_sel,
    output logic [1:0]       o_gpr_sel,
    output logic [2:0]       o_wd_sel,
    output logic [3:0]       o_alu_op,
    output logic             o_alu_bsel,
    output logic             o_bmode,
    output logic [1:0]       o_ext_op,
    output logic             o_dm_req,
    output logic             o_dm_we,
    output logic             o_pr_req,
    output logic             o_pr_we,
    output logic             o_cp0_we,
    output logic             o_exl_set,
    output logic             o_exl_clr,
    output logic             o_epc_sel,
    output logic [4:0]       o_exc_code,
    output logic [IRQ_W-1:0] o_irq_pend,
    output logic [2:0]       o_state
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_EXC} state_t;

    state_t           r_state, w_next, w_bnd;
    logic [CW-1:0]    r_cnt;
    logic [4:0]       r_exc_code, w_code;
    logic [IRQ_W-1:0] r_irq_pend;

    logic [5:0] w_op, w_fn;
    logic [4:0] w_rs;
    logic w_rtype, w_addu, w_subu, w_slt, w_jr, w_ori, w_lui, w_addi, w_addiu;
    logic w_lw, w_lb, w_sw, w_sb, w_beq, w_j, w_jal, w_cop0, w_eret, w_mfc0, w_mtc0;
    logic w_load, w_store, w_alu, w_valid, w_dev, w_int, w_to, w_req, w_unused;

    assign w_op     = i_instr[31:26];
    assign w_fn     = i_instr[5:0];
    assign w_rs     = i_instr[25:21];
    assign w_unused = &{1'b0, i_instr[20:6], i_pr_addr[5:0]};
    assign w_rtype  = w_op == 6'h00;
    assign w_addu   = w_rtype && w_fn == 6'h21;
    assign w_subu   = w_rtype && w_fn == 6'h23;
    assign w_slt    = w_rtype && w_fn == 6'h2a;
    assign w_jr     = w_rtype && w_fn == 6'h08;
    assign w_ori    = w_op == 6'h0d;
    assign w_lui    = w_op == 6'h0f;
    assign w_addi   = w_op == 6'h08;
    assign w_addiu  = w_op == 6'h09;
    assign w_lw     = w_op == 6'h23;
    assign w_lb     = w_op == 6'h20;
    assign w_sw     = w_op == 6'h2b;
    assign w_sb     = w_op == 6'h28;
    assign w_beq    = w_op == 6'h04;
    assign w_j      = w_op == 6'h02;
    assign w_jal    = w_op == 6'h03;
    assign w_cop0   = w_op == 6'h10;
    assign w_eret   = w_cop0 && w_rs == 5'h10 && w_fn == 6'h18;
    assign w_mfc0   = w_cop0 && w_rs == 5'h00;
    assign w_mtc0   = w_cop0 && w_rs == 5'h04;
    assign w_load   = w_lw | w_lb;
    assign w_store  = w_sw | w_sb;
    assign w_alu    = w_addu | w_subu | w_slt | w_ori | w_lui | w_addi | w_addiu;
    assign w_valid  = w_alu | w_load | w_store | w_beq | w_j | w_jal | w_jr | w_eret | w_mfc0 | w_mtc0;

    assign w_dev = i_pr_addr[29:6] == DEV_BASE;
    assign w_int = (|(i_irq & i_im)) & i_ie & ~i_exl;
    assign w_bnd = w_int ? S_EXC : S_FETCH;
    // A ready arriving in the timeout cycle still completes the access
    assign w_to  = r_cnt == TO && !i_mem_ready;
    assign w_req = r_state == S_MEM && !w_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_exc_code <= '0;
            r_irq_pend <= '0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= (r_state == S_MEM && !i_mem_ready) ? r_cnt + 1'b1 : '0;
            r_exc_code <= (w_next == S_EXC) ? w_code : r_exc_code;
            r_irq_pend <= i_irq & i_im;
        end
    end

    always_comb begin
        w_next = r_state;
        w_code = 5'd0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                w_next = w_valid ? S_EXEC : S_EXC;
                w_code = 5'd10;
            end
            S_EXEC: begin
                w_next = (w_addi && i_ovf) ? S_EXC : w_alu ? S_WB : (w_load | w_store) ? S_MEM : w_bnd;
                w_code = (w_addi && i_ovf) ? 5'd12 : 5'd0;
            end
            S_MEM: begin
                w_next = i_mem_ready ? (w_load ? S_WB : w_bnd) : w_to ? S_EXC : S_MEM;
                w_code = i_mem_ready ? 5'd0 : 5'd7;
            end
            S_WB:     w_next = w_bnd;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_pc_wr    = 1'b0;
        o_ir_wr    = 1'b0;
        o_gpr_wr   = 1'b0;
        o_npc_sel  = 3'b000;
        o_gpr_sel  = w_jal ? 2'b10 : w_rtype ? 2'b01 : 2'b00;
        o_wd_sel   = 3'b000;
        o_alu_op   = (w_addu | w_addiu | w_load | w_store) ? 4'h0 : (w_subu | w_beq) ? 4'h1 :
                     w_ori ? 4'h2 : w_lui ? 4'h3 : w_addi ? 4'h5 : w_slt ? 4'h6 : 4'hf;
        o_alu_bsel = w_ori | w_lui | w_addi | w_addiu | w_load | w_store;
        o_bmode    = w_lb | w_sb;
        o_ext_op   = w_lui ? 2'b10 : w_ori ? 2'b00 : 2'b01;
        o_dm_req   = 1'b0;
        o_dm_we    = 1'b0;
        o_pr_req   = 1'b0;
        o_pr_we    = 1'b0;
        o_cp0_we   = 1'b0;
        o_exl_set  = 1'b0;
        o_exl_clr  = 1'b0;
        o_epc_sel  = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_pc_wr  = 1'b1;
                o_ir_wr  = 1'b1;
                o_alu_op = 4'hf;
                o_ext_op = 2'b11;
                o_wd_sel = 3'b111;
            end
            S_EXEC: begin
                o_pc_wr   = w_beq ? i_zero : (w_j | w_jal | w_jr | w_eret);
                o_gpr_wr  = w_jal | w_mfc0;
                o_npc_sel = w_beq ? 3'b001 : (w_j | w_jal) ? 3'b010 : w_jr ? 3'b100 : w_eret ? 3'b110 : 3'b000;
                o_wd_sel  = w_jal ? 3'b010 : w_mfc0 ? 3'b100 : 3'b000;
                o_cp0_we  = w_mtc0 | w_eret;
                o_exl_clr = w_eret;
            end
            S_MEM: begin
                o_dm_req = w_req & ~w_dev;
                o_dm_we  = w_req & ~w_dev & w_store;
                o_pr_req = w_req & w_dev;
                o_pr_we  = w_req & w_dev & w_store;
            end
            S_WB: begin
                o_gpr_wr = 1'b1;
                o_wd_sel = w_load ? (w_dev ? 3'b011 : 3'b001) : 3'b000;
            end
            S_EXC: begin
                o_pc_wr   = 1'b1;
                o_npc_sel = 3'b101;
                o_exl_set = 1'b1;
                o_cp0_we  = 1'b1;
                o_epc_sel = |r_exc_code;
            end
            default: ;
        endcase
        if (rst) begin
            o_pc_wr   = 1'b0;
            o_ir_wr   = 1'b0;
            o_gpr_wr  = 1'b0;
            o_dm_req  = 1'b0;
            o_dm_we   = 1'b0;
            o_pr_req  = 1'b0;
            o_pr_we   = 1'b0;
            o_cp0_we  = 1'b0;
            o_exl_set = 1'b0;
            o_exl_clr = 1'b0;
        end
    end

    assign o_exc_code = r_exc_code;
    assign o_irq_pend = r_irq_pend;
    assign o_state    = r_state;
endmodule

// File: tb/tb_mc_ctrl_irq.sv
// tb_mc_ctrl_irq: directed bench; a per-instruction trace model predicts every
// cycle of each instruction and one compare process checks the DUT against it.
module tb_mc_ctrl_irq;
    localparam int TO = 15;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] i_instr;
    logic [29:0] i_pr_addr;
    logic i_zero, i_ovf, i_ie, i_exl, i_mem_ready;
    logic [5:0] i_irq, i_im, o_irq_pend;
    logic o_pc_wr, o_ir_wr, o_gpr_wr, o_alu_bsel, o_bmode;
    logic o_dm_req, o_dm_we, o_pr_req, o_pr_we, o_cp0_we, o_exl_set, o_exl_clr, o_epc_sel;
    logic [2:0] o_npc_sel, o_wd_sel, o_state;
    logic [1:0] o_gpr_sel, o_ext_op;
    logic [3:0] o_alu_op;
    logic [4:0] o_exc_code;

    mc_ctrl_irq #(.IRQ_W(6), .MEM_TIMEOUT(TO), .DEV_BASE(24'h00007f)) dut (
        .clk(clk), .rst(rst), .i_instr(i_instr), .i_pr_addr(i_pr_addr), .i_zero(i_zero),
        .i_ovf(i_ovf), .i_irq(i_irq), .i_im(i_im), .i_ie(i_ie), .i_exl(i_exl),
        .i_mem_ready(i_mem_ready), .o_pc_wr(o_pc_wr), .o_ir_wr(o_ir_wr), .o_gpr_wr(o_gpr_wr),
        .o_npc_sel(o_npc_sel), .o_gpr_sel(o_gpr_sel), .o_wd_sel(o_wd_sel), .o_alu_op(o_alu_op),
        .o_alu_bsel(o_alu_bsel), .o_bmode(o_bmode), .o_ext_op(o_ext_op), .o_dm_req(o_dm_req),
        .o_dm_we(o_dm_we), .o_pr_req(o_pr_req), .o_pr_we(o_pr_we), .o_cp0_we(o_cp0_we),
        .o_exl_set(o_exl_set), .o_exl_clr(o_exl_clr), .o_epc_sel(o_epc_sel),
        .o_exc_code(o_exc_code), .o_irq_pend(o_irq_pend), .o_state(o_state)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] SUBU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23};
    localparam logic [31:0] SLT   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2a};
    localparam logic [31:0] JR    = {6'h00, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] RBAD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f};
    localparam logic [31:0] ORI   = {6'h0d, 5'd1, 5'd2, 16'h0055};
    localparam logic [31:0] LUI   = {6'h0f, 5'd0, 5'd2, 16'h1234};
    localparam logic [31:0] ADDI  = {6'h08, 5'd1, 5'd2, 16'hfff0};
    localparam logic [31:0] ADDIU = {6'h09, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] LW    = {6'h23, 5'd1, 5'd2, 16'h0000};
    localparam logic [31:0] LB    = {6'h20, 5'd1, 5'd2, 16'h0001};
    localparam logic [31:0] SW    = {6'h2b, 5'd1, 5'd2, 16'h0000};
    localparam logic [31:0] SB    = {6'h28, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] BEQ   = {6'h04, 5'd1, 5'd2, 16'h0010};
    localparam logic [31:0] JMP   = {6'h02, 26'h0000100};
    localparam logic [31:0] JAL   = {6'h03, 26'h0000200};
    localparam logic [31:0] ERET  = 32'h42000018;
    localparam logic [31:0] MFC0  = {6'h10, 5'd0, 5'd2, 5'd12, 11'd0};
    localparam logic [31:0] MTC0  = {6'h10, 5'd4, 5'd2, 5'd12, 11'd0};
    localparam logic [31:0] BAD   = {6'h3f, 26'd0};

    typedef struct packed {
        logic [2:0] st;
        logic pcw, irw, gw, cpw, dmr, prr, we, xset, xclr, rdy, epc;
        logic [2:0] npc, wd;
        logic [1:0] gs;
        logic [3:0] aop;
        logic [4:0] code;
    } rec_t;

    rec_t q[$];
    int n_chk = 0, n_err = 0, n_prreq = 0, last_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [2:0] st);
        rec_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    function automatic rec_t ex(input logic [4:0] code, input logic epc);
        rec_t r;
        r = mk(3'd5);
        r.pcw = 1'b1; r.npc = 3'b101; r.cpw = 1'b1; r.xset = 1'b1; r.code = code; r.epc = epc;
        return r;
    endfunction

    // Expected per-cycle trace of one instruction, from FETCH to its last cycle
    task automatic build(input logic [31:0] ins, input bit dev, input int nw, input bit ov, input bit zf);
        rec_t r;
        int kind;
        bit intr;
        logic [5:0] op, fn;
        logic [4:0] rs;
        op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21];
        intr = (|(i_irq & i_im)) && i_ie && !i_exl;
        r = mk(3'd0); r.pcw = 1'b1; r.irw = 1'b1; q.push_back(r);
        q.push_back(mk(3'd1));
        r = mk(3'd2);
        r.aop = 4'hf;
        kind = 0;
        case (op)
            6'h00: case (fn)
                6'h21: begin kind = 1; r.aop = 4'h0; end
                6'h23: begin kind = 1; r.aop = 4'h1; end
                6'h2a: begin kind = 1; r.aop = 4'h6; end
                6'h08: begin kind = 5; r.pcw = 1'b1; r.npc = 3'b100; end
                default: kind = 0;
            endcase
            6'h0d: begin kind = 1; r.aop = 4'h2; end
            6'h0f: begin kind = 1; r.aop = 4'h3; end
            6'h09: begin kind = 1; r.aop = 4'h0; end
            6'h08: begin kind = 2; r.aop = 4'h5; end
            6'h23, 6'h20: begin kind = 3; r.aop = 4'h0; end
            6'h2b, 6'h28: begin kind = 4; r.aop = 4'h0; end
            6'h04: begin kind = 5; r.aop = 4'h1; r.pcw = zf; r.npc = 3'b001; end
            6'h02: begin kind = 5; r.pcw = 1'b1; r.npc = 3'b010; end
            6'h03: begin kind = 5; r.pcw = 1'b1; r.npc = 3'b010; r.gw = 1'b1; r.wd = 3'b010; r.gs = 2'b10; end
            6'h10: begin
                if (rs == 5'h00) begin kind = 5; r.gw = 1'b1; r.wd = 3'b100; end
                else if (rs == 5'h04) begin kind = 5; r.cpw = 1'b1; end
                else if (rs == 5'h10 && fn == 6'h18) begin
                    kind = 5; r.pcw = 1'b1; r.npc = 3'b110; r.cpw = 1'b1; r.xclr = 1'b1;
                end
            end
            default: kind = 0;
        endcase
        if (kind == 0) begin
            q.push_back(ex(5'd10, 1'b1));
            return;
        end
        q.push_back(r);
        if (kind == 2 && ov) begin
            q.push_back(ex(5'd12, 1'b1));
            return;
        end
        if (kind == 3 || kind == 4) begin
            for (int i = 0; i < ((nw > TO) ? TO : nw); i++) begin
                r = mk(3'd3); r.dmr = !dev; r.prr = dev; r.we = (kind == 4); q.push_back(r);
            end
            if (nw > TO) begin
                q.push_back(mk(3'd3));
                q.push_back(ex(5'd7, 1'b1));
                return;
            end
            r = mk(3'd3); r.dmr = !dev; r.prr = dev; r.we = (kind == 4); r.rdy = 1'b1; q.push_back(r);
        end
        if (kind != 4 && kind != 5) begin
            r = mk(3'd4); r.gw = 1'b1;
            r.wd = (kind == 3) ? (dev ? 3'b011 : 3'b001) : 3'b000;
            r.gs = (op == 6'h00) ? 2'b01 : 2'b00;
            q.push_back(r);
        end
        if (intr) q.push_back(ex(5'd0, 1'b0));
    endtask

    initial begin
        rec_t r;
        i_mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2 i_mem_ready = (q.size() > 0) ? q[0].rdy : 1'b0;
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                if (o_pr_req) n_prreq++;
                chk("state", o_state, r.st);
                chk("pc_wr", o_pc_wr, r.pcw);
                chk("ir_wr", o_ir_wr, r.irw);
                chk("gpr_wr", o_gpr_wr, r.gw);
                chk("cp0_we", o_cp0_we, r.cpw);
                chk("dm_req", o_dm_req, r.dmr);
                chk("pr_req", o_pr_req, r.prr);
                chk("mem_we", o_dm_we | o_pr_we, r.we);
                chk("exl_set", o_exl_set, r.xset);
                chk("exl_clr", o_exl_clr, r.xclr);
                if (r.pcw) chk("npc_sel", o_npc_sel, r.npc);
                if (r.gw) begin
                    chk("wd_sel", o_wd_sel, r.wd);
                    chk("gpr_sel", o_gpr_sel, r.gs);
                end
                if (r.st == 3'd2) chk("alu_op", o_alu_op, r.aop);
                if (r.st == 3'd5) begin
                    chk("exc_code", o_exc_code, r.code);
                    chk("epc_sel", o_epc_sel, r.epc);
                end
            end
        end
    end

    task automatic run(input logic [31:0] ins, input logic [29:0] addr, input int nw, input bit ov, input bit zf);
        int c;
        i_instr = ins; i_pr_addr = addr; i_ovf = ov; i_zero = zf;
        build(ins, addr[29:6] == 24'h7f, nw, ov, zf);
        last_len = q.size();
        c = 0;
        while (q.size() > 0 && c < 100) begin
            @(negedge clk);
            #1 c++;
        end
        if (q.size() > 0) begin
            chk("trace_timeout", q.size(), 0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        i_instr = 32'd0; i_pr_addr = 30'd0; i_zero = 1'b0; i_ovf = 1'b0;
        i_irq = 6'h3f; i_im = 6'h3f; i_ie = 1'b1; i_exl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", o_state, 3'd0);
        chk("rst_pc_wr", o_pc_wr, 1'b0);
        chk("rst_ir_wr", o_ir_wr, 1'b0);
        chk("rst_irq_pend", o_irq_pend, 6'h00);
        chk("rst_exc_code", o_exc_code, 5'd0);
        i_irq = 6'h00; i_im = 6'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        run(ADDU, 30'd0, 0, 0, 0);
        chk("addu_len", last_len, 4);
        run(SUBU, 30'd0, 0, 0, 0);
        run(SLT, 30'd0, 0, 0, 0);
        run(LUI, 30'd0, 0, 0, 0);
        run(ADDIU, 30'd0, 0, 0, 0);
        run(ADDI, 30'd0, 0, 0, 0);
        run(LW, 30'h1000, 3, 0, 0);
        chk("lw_len", last_len, 8);
        run(LB, 30'h1fc0, 0, 0, 0);
        run(SB, 30'h1000, 2, 0, 0);
        run(LW, 30'h1000, TO, 0, 0);
        n_prreq = 0;
        run(SW, 30'h1fc0, 99, 0, 0);
        chk("to_pr_req_cycles", n_prreq, 15);
        chk("to_exc_code", o_exc_code, 5'd7);
        run(ADDI, 30'd0, 0, 1, 0);
        chk("ovf_exc_code", o_exc_code, 5'd12);
        i_irq = 6'b001000; i_im = 6'b001000; i_ie = 1'b1; i_exl = 1'b0;
        run(ORI, 30'd0, 0, 0, 0);
        chk("irq_pend", o_irq_pend, 6'b001000);
        chk("irq_exc_code", o_exc_code, 5'd0);
        chk("irq_len", last_len, 5);
        run(ADDI, 30'd0, 0, 1, 0);
        run(SB, 30'h1000, 2, 0, 0);
        run(BEQ, 30'd0, 0, 0, 1);
        i_exl = 1'b1;
        run(ORI, 30'd0, 0, 0, 0);
        i_exl = 1'b0; i_ie = 1'b0;
        run(ORI, 30'd0, 0, 0, 0);
        i_ie = 1'b1; i_im = 6'b000000;
        run(ORI, 30'd0, 0, 0, 0);
        chk("irq_pend_masked", o_irq_pend, 6'b000000);
        chk("masked_len", last_len, 4);
        i_irq = 6'b000000;
        run(BAD, 30'd0, 0, 0, 0);
        chk("ri_exc_code", o_exc_code, 5'd10);
        run(RBAD, 30'd0, 0, 0, 0);
        run(ERET, 30'd0, 0, 0, 0);
        run(JMP, 30'd0, 0, 0, 0);
        run(JAL, 30'd0, 0, 0, 0);
        run(JR, 30'd0, 0, 0, 0);
        run(BEQ, 30'd0, 0, 0, 1);
        run(BEQ, 30'd0, 0, 0, 0);
        run(MFC0, 30'd0, 0, 0, 0);
        run(MTC0, 30'd0, 0, 0, 0);
        i_instr = SW; i_pr_addr = 30'h1000;
        c = 0;
        while (o_state !== 3'd3 && c < 10) begin
            @(posedge clk);
            #1 c++;
        end
        chk("rm_state", o_state, 3'd3);
        chk("rm_dm_we_pre", o_dm_we, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rm_dm_req", o_dm_req, 1'b0);
        chk("rm_dm_we", o_dm_we, 1'b0);
        chk("rm_state_rst", o_state, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        run(LW, 30'h1000, 12, 0, 0);
        run(ADDU, 30'd0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
